// File: rtl/zb_deframer.sv
// Receive-side 802.15.4 deframer: preamble/SFD hunt, PHR length check, payload nibble packing into the FIFO.
// Define ZB_DEFRAMER_CRC_EN to add the bit-serial CRC-16 frame check reported on outCrcOk.
module zb_deframer #(
    parameter int unsigned PREAMBLE_ZEROS = 8,
    parameter logic [7:0]  SFD_VALUE      = 8'hA7,
    parameter int unsigned MAX_LEN        = 127,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inFlag,
    input  logic       inData,
    input  logic       inFull,
    output logic       outWriteEnable,
    output logic [3:0] outData,
    output logic       outFrameStart,
    output logic [6:0] outLength,
    output logic       outFrameDone,
    output logic       outFrameError,
    output logic       outCrcOk,
    output logic       outBusy
);
    localparam int unsigned ZERO_W  = $clog2(PREAMBLE_ZEROS + 1);
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
`ifdef ZB_DEFRAMER_CRC_EN
    localparam int unsigned MIN_LEN = 2;
`else
    localparam int unsigned MIN_LEN = 1;
`endif

    typedef enum logic [1:0] {HUNT, SYNC, PHR, PAYLOAD} stateType;

    stateType            state, stateNext;
    logic [ZERO_W-1:0]   zeroCnt, zeroCntNext;
    logic [7:0]          shiftReg, shiftNext, shifted;
    logic [2:0]          bitCnt, bitCntNext;
    logic                seenOne, seenOneNext;
    logic [TIMER_W-1:0]  timer, timerNext;
    logic [7:0]          nibbleCnt, nibbleCntNext;
    logic                lastWrite, lastWriteNext;
    logic                writeNext, startNext, doneNext, errorNext;
    logic [3:0]          dataNext;
    logic [6:0]          lengthNext;
    logic                timedOut, abort;
    logic [7:0]          phrLen;
`ifdef ZB_DEFRAMER_CRC_EN
    logic [15:0]         crc, crcNext;
    logic                crcFeedback, crcOkNext;
`endif

    // Next-state and next-output logic; every register's next value is decided here.
    always_comb begin
        stateNext     = state;
        zeroCntNext   = zeroCnt;
        shiftNext     = shiftReg;
        bitCntNext    = bitCnt;
        seenOneNext   = seenOne;
        timerNext     = timer;
        nibbleCntNext = nibbleCnt;
        lastWriteNext = 1'b0;
        writeNext     = 1'b0;
        dataNext      = outData;
        startNext     = 1'b0;
        lengthNext    = outLength;
        doneNext      = 1'b0;
        errorNext     = 1'b0;
        timedOut      = 1'b0;
        abort         = 1'b0;
        shifted       = {inData, shiftReg[7:1]};
        phrLen        = {1'b0, shifted[6:0]};
`ifdef ZB_DEFRAMER_CRC_EN
        crcNext       = crc;
        crcOkNext     = outCrcOk;
        crcFeedback   = crc[0] ^ inData;
`endif

        // Inter-bit watchdog; a bit arriving in the expiry cycle wins.
        if (state == PHR || state == PAYLOAD || (state == SYNC && seenOne)) begin
            timerNext = inFlag ? TIMER_W'(1) : timer + TIMER_W'(1);
            timedOut  = !inFlag && !lastWrite && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
        end

        case (state)
            HUNT: begin
                if (inFlag) begin
                    if (inData) begin
                        zeroCntNext = '0;
                    end else if (zeroCnt != ZERO_W'(PREAMBLE_ZEROS)) begin
                        zeroCntNext = zeroCnt + ZERO_W'(1);
                    end
                    if (!inData && zeroCnt + ZERO_W'(1) >= ZERO_W'(PREAMBLE_ZEROS)) begin
                        stateNext   = SYNC;
                        seenOneNext = 1'b0;
                        bitCntNext  = '0;
                    end
                end
            end
            SYNC: begin
                // Leading zeros before the first 1 extend the preamble.
                if (inFlag && (seenOne || inData)) begin
                    seenOneNext = 1'b1;
                    shiftNext   = shifted;
                    bitCntNext  = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        bitCntNext = '0;
                        stateNext  = (shifted == SFD_VALUE) ? PHR : HUNT;
                    end
                end
            end
            PHR: begin
                if (inFlag) begin
                    shiftNext  = shifted;
                    bitCntNext = bitCnt + 3'd1;
                    if (bitCnt == 3'd7) begin
                        bitCntNext = '0;
                        if (phrLen < 8'(MIN_LEN) || phrLen > 8'(MAX_LEN)) begin
                            abort = 1'b1;
                        end else begin
                            startNext     = 1'b1;
                            lengthNext    = shifted[6:0];
                            nibbleCntNext = '0;
                            stateNext     = PAYLOAD;
`ifdef ZB_DEFRAMER_CRC_EN
                            crcNext       = '0;
`endif
                        end
                    end
                end
            end
            PAYLOAD: begin
                if (lastWrite) begin
                    doneNext  = 1'b1;
                    stateNext = HUNT;
`ifdef ZB_DEFRAMER_CRC_EN
                    crcOkNext = (crc == 16'h0000);
`endif
                end else if (inFlag) begin
                    shiftNext  = shifted;
                    bitCntNext = bitCnt + 3'd1;
`ifdef ZB_DEFRAMER_CRC_EN
                    crcNext    = {1'b0, crc[15:1]} ^ (crcFeedback ? 16'h8408 : 16'h0000);
`endif
                    // The nibble's first bit sits at shifted[4] once four bits are in.
                    if (bitCnt[1:0] == 2'd3) begin
                        bitCntNext = '0;
                        if (inFull) begin
                            abort = 1'b1;
                        end else begin
                            writeNext     = 1'b1;
                            dataNext      = shifted[7:4];
                            nibbleCntNext = nibbleCnt + 8'd1;
                            lastWriteNext = (nibbleCnt + 8'd1 == {outLength, 1'b0});
                        end
                    end
                end
            end
            default: stateNext = HUNT;
        endcase

        if (timedOut) begin
            abort = 1'b1;
        end
        if (abort) begin
            errorNext = 1'b1;
            stateNext = HUNT;
        end
        if (stateNext == HUNT) begin
            timerNext = '0;
            if (state != HUNT) begin
                zeroCntNext = '0;
            end
        end
    end

    always_ff @(posedge inClock) begin
        if (!inReset) begin
            state          <= HUNT;
            zeroCnt        <= '0;
            shiftReg       <= '0;
            bitCnt         <= '0;
            seenOne        <= 1'b0;
            timer          <= '0;
            nibbleCnt      <= '0;
            lastWrite      <= 1'b0;
            outWriteEnable <= 1'b0;
            outData        <= '0;
            outFrameStart  <= 1'b0;
            outLength      <= '0;
            outFrameDone   <= 1'b0;
            outFrameError  <= 1'b0;
            outBusy        <= 1'b0;
        end else begin
            state          <= stateNext;
            zeroCnt        <= zeroCntNext;
            shiftReg       <= shiftNext;
            bitCnt         <= bitCntNext;
            seenOne        <= seenOneNext;
            timer          <= timerNext;
            nibbleCnt      <= nibbleCntNext;
            lastWrite      <= lastWriteNext;
            outWriteEnable <= writeNext;
            outData        <= dataNext;
            outFrameStart  <= startNext;
            outLength      <= lengthNext;
            outFrameDone   <= doneNext;
            outFrameError  <= errorNext;
            outBusy        <= (stateNext != HUNT);
        end
    end

`ifdef ZB_DEFRAMER_CRC_EN
    always_ff @(posedge inClock) begin
        if (!inReset) begin
            crc      <= '0;
            outCrcOk <= 1'b1;
        end else begin
            crc      <= crcNext;
            outCrcOk <= crcOkNext;
        end
    end
`else
    assign outCrcOk = 1'b1;
`endif

endmodule

// File: tb/tb_zb_deframer.sv
// Self-checking bench for zb_deframer: scoreboarded nibble writes plus per-scenario pulse/timing checks.
`timescale 1ns/1ps
module tb_zb_deframer;
    localparam int TIMEOUT = 4096;

    logic       inClock = 1'b0;
    logic       inReset = 1'b0;
    logic       inFlag  = 1'b0;
    logic       inData  = 1'b0;
    logic       inFull  = 1'b0;
    logic       outWriteEnable;
    logic [3:0] outData;
    logic       outFrameStart;
    logic [6:0] outLength;
    logic       outFrameDone;
    logic       outFrameError;
    logic       outCrcOk;
    logic       outBusy;

    int checks = 0;
    int errors = 0;
    logic [3:0] expQ[$];
    logic [3:0] expNib;
    int cyc = 0;
    int flagCyc = 0;
    int wrCount, startCount, doneCount, errCount;
    int lastWriteCyc, doneCyc, errCyc;
    logic [6:0] startLen;
    logic crcAtDone;

    zb_deframer dut (
        .inClock(inClock), .inReset(inReset), .inFlag(inFlag), .inData(inData), .inFull(inFull),
        .outWriteEnable(outWriteEnable), .outData(outData), .outFrameStart(outFrameStart),
        .outLength(outLength), .outFrameDone(outFrameDone), .outFrameError(outFrameError),
        .outCrcOk(outCrcOk), .outBusy(outBusy)
    );

    always #5 inClock = ~inClock;
    always @(posedge inClock) cyc++;

    // Output monitor: pops the scoreboard on each write and records pulse events.
    always @(negedge inClock) begin
        if (outWriteEnable) begin
            wrCount++;
            lastWriteCyc = cyc;
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got nibble %h, expected no write", outData);
            end else begin
                expNib = expQ.pop_front();
                if (outData !== expNib) begin
                    errors++;
                    $display("FAIL write_data: got %h expected %h", outData, expNib);
                end
            end
        end
        if (outFrameStart) begin
            startCount++;
            startLen = outLength;
        end
        if (outFrameDone) begin
            doneCount++;
            doneCyc   = cyc;
            crcAtDone = outCrcOk;
        end
        if (outFrameError) begin
            errCount++;
            errCyc = cyc;
        end
        if (outFrameDone || outFrameError) begin
            checks++;
            if (outFrameDone && outFrameError) begin
                errors++;
                $display("FAIL pulse_exclusive: done=%b error=%b together", outFrameDone, outFrameError);
            end
        end
    end

    task automatic clearCounts();
        expQ.delete();
        wrCount = 0; startCount = 0; doneCount = 0; errCount = 0;
        lastWriteCyc = 0; doneCyc = 0; errCyc = 0; startLen = '0; crcAtDone = 1'b0;
    endtask

    task automatic doReset();
        @(posedge inClock); #1;
        inReset = 1'b0; inFlag = 1'b0; inData = 1'b0; inFull = 1'b0;
        repeat (3) @(posedge inClock);
        #1 inReset = 1'b1;
        clearCounts();
    endtask

    task automatic sendBit(input logic b);
        @(posedge inClock); #1;
        inFlag = 1'b1; inData = b; flagCyc = cyc;
        @(posedge inClock); #1;
        inFlag = 1'b0;
        repeat (2) @(posedge inClock);
    endtask

    task automatic sendByte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
    endtask

    task automatic sendZeros(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b0);
    endtask

    task automatic pushByte(input logic [7:0] b);
        expQ.push_back(b[3:0]);
        expQ.push_back(b[7:4]);
    endtask

    task automatic checkInt(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        inReset = 1'b0; inFlag = 1'b1; inData = 1'b1; inFull = 1'b1;
        repeat (3) @(posedge inClock);
        @(negedge inClock);
        checks++; if (outWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", outWriteEnable); end
        checks++; if (outData !== 4'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", outData); end
        checks++; if (outFrameStart !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", outFrameStart); end
        checks++; if (outLength !== 7'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", outLength); end
        checks++; if (outFrameDone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", outFrameDone); end
        checks++; if (outFrameError !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", outFrameError); end
        checks++; if (outBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", outBusy); end
        checks++; if (outCrcOk !== 1'b1) begin errors++; $display("FAIL reset_crcok: got %b expected 1", outCrcOk); end
        inFlag = 1'b0; inData = 1'b0; inFull = 1'b0;
        @(posedge inClock); #1 inReset = 1'b1;
        clearCounts();
    endtask

    task automatic test_basic_frame();
        doReset();
        sendZeros(8);
        sendByte(8'hA7);
        @(negedge inClock);
        checks++; if (outBusy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", outBusy); end
        sendByte(8'h02);
        pushByte(8'h3C);
        pushByte(8'h5A);
        sendByte(8'h3C);
        sendByte(8'h5A);
        repeat (10) @(posedge inClock);
        checkInt("basic_writes", wrCount, 4);
        checkInt("basic_starts", startCount, 1);
        checkInt("basic_start_len", int'(startLen), 2);
        checkInt("basic_done", doneCount, 1);
        checkInt("basic_done_delay", doneCyc - lastWriteCyc, 1);
        checkInt("basic_errors", errCount, 0);
        checkInt("basic_queue_left", expQ.size(), 0);
        checkInt("basic_len_held", int'(outLength), 2);
        checkInt("basic_busy_after", int'(outBusy), 0);
`ifndef ZB_DEFRAMER_CRC_EN
        checkInt("basic_crcok", int'(crcAtDone), 1);
`endif
    endtask

    task automatic test_bad_sfd();
        doReset();
        sendZeros(8);
        sendByte(8'hA6);
        sendBit(1'b0);
        @(negedge inClock);
        checkInt("badsfd_busy", int'(outBusy), 0);
        checkInt("badsfd_no_err", errCount, 0);
        sendZeros(15);
        sendByte(8'hA7);
        sendByte(8'h02);
        pushByte(8'h96);
        pushByte(8'h0F);
        sendByte(8'h96);
        sendByte(8'h0F);
        repeat (10) @(posedge inClock);
        checkInt("badsfd_writes", wrCount, 4);
        checkInt("badsfd_starts", startCount, 1);
        checkInt("badsfd_len", int'(startLen), 2);
        checkInt("badsfd_done", doneCount, 1);
        checkInt("badsfd_errors", errCount, 0);
    endtask

    task automatic test_bad_length();
        doReset();
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h00);
        repeat (5) @(posedge inClock);
        checkInt("len0_errors", errCount, 1);
        checkInt("len0_writes", wrCount, 0);
        checkInt("len0_busy", int'(outBusy), 0);
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h80);
        repeat (5) @(posedge inClock);
        checkInt("len80_errors", errCount, 2);
        checkInt("len80_writes", wrCount, 0);
        checkInt("len80_starts", startCount, 0);
        checkInt("len80_done", doneCount, 0);
`ifdef ZB_DEFRAMER_CRC_EN
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h01);
        repeat (5) @(posedge inClock);
        checkInt("len1_crc_errors", errCount, 3);
        checkInt("len1_crc_starts", startCount, 0);
`endif
    endtask

    task automatic test_fifo_full();
        logic [7:0] pay;
        pay = 8'h96;
        doReset();
        sendZeros(8);
        sendByte(8'hA7);
`ifdef ZB_DEFRAMER_CRC_EN
        sendByte(8'h02);
`else
        sendByte(8'h01);
`endif
        expQ.push_back(pay[3:0]);
        for (int i = 0; i < 4; i++) sendBit(pay[i]);
        #1 inFull = 1'b1;
        for (int i = 4; i < 8; i++) sendBit(pay[i]);
        repeat (5) @(posedge inClock);
        #1 inFull = 1'b0;
        checkInt("full_writes", wrCount, 1);
        checkInt("full_errors", errCount, 1);
        checkInt("full_done", doneCount, 0);
        checkInt("full_busy", int'(outBusy), 0);
    endtask

    task automatic test_timeout();
        int errBefore;
        doReset();
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h04);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        for (int i = 0; i < TIMEOUT + 200; i++) begin
            @(posedge inClock);
            if (errCount != 0) break;
        end
        checkInt("timeout_errors", errCount, 1);
        checkInt("timeout_delay", errCyc - flagCyc, TIMEOUT);
        checkInt("timeout_writes", wrCount, 0);
        checkInt("timeout_busy", int'(outBusy), 0);

        // Repeat run, reset while mid-payload.
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h04);
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        errBefore = errCount;
        repeat (50) @(posedge inClock);
        #1 inReset = 1'b0;
        repeat (2) @(posedge inClock);
        @(negedge inClock);
        checkInt("midrst_outputs", int'({outWriteEnable, outData, outFrameStart, outLength,
                                          outFrameDone, outFrameError, outBusy}), 0);
        checkInt("midrst_crcok", int'(outCrcOk), 1);
        @(posedge inClock); #1 inReset = 1'b1;
        repeat (TIMEOUT + 100) @(posedge inClock);
        checkInt("midrst_no_error", errCount - errBefore, 0);
        checkInt("midrst_busy", int'(outBusy), 0);
    endtask

`ifdef ZB_DEFRAMER_CRC_EN
    task automatic test_crc();
        doReset();
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h02);
        pushByte(8'h00);
        pushByte(8'h00);
        sendByte(8'h00);
        sendByte(8'h00);
        repeat (10) @(posedge inClock);
        checkInt("crc_good_writes", wrCount, 4);
        checkInt("crc_good_done", doneCount, 1);
        checkInt("crc_good_ok", int'(crcAtDone), 1);
        clearCounts();
        sendZeros(8);
        sendByte(8'hA7);
        sendByte(8'h02);
        pushByte(8'h00);
        pushByte(8'h01);
        sendByte(8'h00);
        sendByte(8'h01);
        repeat (10) @(posedge inClock);
        checkInt("crc_bad_writes", wrCount, 4);
        checkInt("crc_bad_done", doneCount, 1);
        checkInt("crc_bad_ok", int'(crcAtDone), 0);
        checkInt("crc_bad_errors", errCount, 0);
    endtask
`endif

    initial begin
        clearCounts();
        test_reset();
        test_basic_frame();
        test_bad_sfd();
        test_bad_length();
        test_fifo_full();
        test_timeout();
`ifdef ZB_DEFRAMER_CRC_EN
        test_crc();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/zb_deframer.md
Name: zb_deframer

Overview:
- Receive-side framing stage between the clock/data recovery block and the output FIFO.
- Consumes the recovered serial bit stream (one bit per valid flag) and hunts for the 802.15.4 preamble and SFD.
- Extracts the 7-bit PHR length and packs payload bits into 4-bit nibbles, which it writes into the output FIFO.
- Reports frame start, done and error status to the test muxing and the host.

Parameters:
- PREAMBLE_ZEROS, 8: minimum consecutive 0 bits required before SFD search starts.
- SFD_VALUE, 8'hA7: start-of-frame delimiter, received LSB first.
- MAX_LEN, 127: largest legal PHR length in bytes.
- TIMEOUT_CYCLES, 4096: maximum clock cycles allowed between two valid bits once SFD search has seen its first 1.

Ports:
- inClock, input, 1: system clock.
- inReset, input, 1: synchronous, active-low reset.
- inFlag, input, 1: recovered bit valid, one-cycle pulse.
- inData, input, 1: recovered bit; sampled when inFlag=1.
- inFull, input, 1: output FIFO full.
- outWriteEnable, output, 1: FIFO write strobe, one cycle per nibble.
- outData, output, 4: nibble to FIFO.
- outFrameStart, output, 1: one-cycle pulse when a valid PHR is accepted.
- outLength, output, 7: PHR length; held from frame start until the next frame start.
- outFrameDone, output, 1: one-cycle pulse after the last nibble is written.
- outFrameError, output, 1: one-cycle pulse on any abort.
- outCrcOk, output, 1: frame check result; valid while outFrameDone=1.
- outBusy, output, 1: high in SYNC, PHR and PAYLOAD states.

Behaviour:
- Reset: the clock is inClock; reset is inReset, synchronous and active-low.
  - When inReset=0 at a rising edge: state=HUNT; all counters, shift registers and outputs go to 0, except outCrcOk=1.
  - No partial nibble is written. Reset mid-frame discards the frame silently, with no error pulse.
- State machine: HUNT -> SYNC -> PHR -> PAYLOAD -> HUNT.
- Bits are consumed only in cycles with inFlag=1. All bit fields are LSB first.
- HUNT:
  - zero_cnt increments on each valid 0 bit, saturating at PREAMBLE_ZEROS; a valid 1 bit clears it.
  - When zero_cnt reaches PREAMBLE_ZEROS, go to SYNC.
- SYNC:
  - While no 1 has yet been received, valid 0 bits are absorbed (extended preamble).
  - The first valid 1 starts an 8-bit capture, including that bit.
  - After 8 bits: if the byte equals SFD_VALUE, go to PHR. Otherwise go to HUNT with zero_cnt=0 and no error pulse.
- PHR:
  - Capture 8 bits; length = phr[6:0]; bit 7 is ignored.
  - If length=0 or length>MAX_LEN: pulse outFrameError and go to HUNT.
  - Otherwise, in the cycle after the 8th bit: pulse outFrameStart, load outLength, and go to PAYLOAD.
- PAYLOAD:
  - Bits shift into a 4-bit register.
  - In the cycle after the valid cycle carrying the 4th bit: outWriteEnable=1 and outData=the nibble. The low nibble of each byte is written first.
  - Total nibbles written = 2*length.
  - If inFull=1 in the cycle a write is due: no write, pulse outFrameError, go to HUNT. Nibbles already written remain in the FIFO.
  - The cycle after the final write: pulse outFrameDone, go to HUNT.
  - An inFlag arriving in a write cycle is accepted normally; there is no stall.
- Timeout:
  - A cycle counter runs in SYNC (after the first 1), PHR and PAYLOAD, and resets on every inFlag.
  - If it reaches TIMEOUT_CYCLES: pulse outFrameError, go to HUNT.
- Simultaneous events: a timeout and a valid bit in the same cycle resolve in favour of the bit.
- Pulse exclusivity: outFrameError and outFrameDone never assert together.

Optional Feature:
- Macro: ZB_DEFRAMER_CRC_EN.
- Defined:
  - A CRC-16 (poly x^16+x^12+x^5+1, init 0x0000, LSB-first bit-serial) is computed over all payload bits, including the 2-byte FCS.
  - outCrcOk = (residue==0), presented with outFrameDone.
  - A PHR length below 2 is an error.
  - A frame with a bad CRC is still written to the FIFO; it is flagged only via outCrcOk=0.
- Undefined: no CRC logic; outCrcOk is tied to 1; the minimum legal length is 1.

Test Plan:
- Frame: 8 zeros, SFD 0xA7, PHR 0x02, payload 0x3C 0x5A, with inFlag every 4 cycles. Expected response:
  - Writes C,3,A,5 in order.
  - One outFrameStart with outLength=2.
  - outFrameDone one cycle after the 4th write.
  - No error.
- Same preamble, then byte 0xA6 instead of the SFD, then a valid frame. Expected response:
  - First attempt returns to HUNT without an error pulse.
  - Second frame is decoded only after a fresh 8-zero preamble.
- PHR 0x00, then PHR 0x80. Expected response:
  - Each produces an outFrameError pulse, no writes, return to HUNT.
  - The 0x80 case fails because its length field is 0; bit 7 is ignored.
- PHR 0x01; inFull=1 when the 2nd nibble is due. Expected response:
  - Exactly 1 write.
  - outFrameError pulse.
  - No outFrameDone.
- PHR 0x04; inFlag stops after 3 payload bits. Expected response:
  - outFrameError exactly TIMEOUT_CYCLES cycles after the last flag.
  - inReset=0 mid-PAYLOAD in a repeat run leaves all outputs at 0 with no error pulse.
- With ZB_DEFRAMER_CRC_EN: payload 0x00 0x00 (FCS of an empty MSDU) gives outCrcOk=1; payload 0x00 0x01 gives outCrcOk=0; 4 writes in both cases.
